rptr_empty_fwft: RTL and testbench

Read-side controller of the dual-clock FIFO, the counterpart that consumes the synchronized write pointer.
- Tracks the read pointer in binary and Gray, and generates the registered empty flag.
- Drives the synchronous-read memory port.
- Presents data through a first-word-fall-through valid/ready output backed by a 2-entry skid buffer, so a consumer can pop one word per rclk.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fwft_skid_buf.sv | 62 ++++++
 rtl/rptr_empty_fwft.sv | 103 ++++++++++
 tb/tb_rptr_empty_fwft.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary conversion and default widths.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 3;
    localparam int unsigned FIFO_DATA_WIDTH = 8;

    // Binary to reflected Gray; callers zero-extend narrower pointers.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray to binary; leading zero bits leave the result unaffected.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fwft_skid_buf.sv
// Two-entry first-word-fall-through buffer: dout is always the oldest word.
// The producer guarantees it never pushes into a full buffer without a pop.
module fwft_skid_buf #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    logic [DATA_WIDTH-1:0] tail;
    logic                  do_pop;

    // A pop is only meaningful while a word is presented.
    assign do_pop = pop & dout_valid;

    // Head/tail storage with simultaneous push and pop keeping occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            dout       <= '0;
            tail       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        dout <= push_data;
                    end else if (count == 2'd1) begin
                        tail <= push_data;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                    dout_valid <= 1'b1;
                end
                2'b01: begin
                    dout       <= tail;
                    tail       <= '0;
                    count      <= count - 2'd1;
                    dout_valid <= (count == 2'd2);
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        dout <= tail;
                        tail <= push_data;
                    end else begin
                        dout <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side controller of the dual-clock FIFO: binary/Gray read pointer,
// registered empty flag, synchronous-read memory port and a FWFT output
// backed by a 2-entry skid buffer.
// Optional macro RPTR_RLEVEL_EN adds the rlevel / almost_empty outputs.
module rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
`ifdef RPTR_RLEVEL_EN
    ,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
`endif
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wptr_sync,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rden,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
`ifdef RPTR_RLEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  almost_empty
`endif
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] rbin_next;
    logic [ADDR_WIDTH:0] rgray_next;
    logic                inflight;
    logic [1:0]          buf_count;
    logic [1:0]          credit;
    logic [1:0]          credit_after_pop;
    logic                pop;

    // Credit = words already buffered plus the word whose read is in flight.
    assign pop              = dout_valid & dout_ready;
    assign credit           = buf_count + {1'b0, inflight};
    assign credit_after_pop = credit - {1'b0, pop};

    // Issue a read only when storage holds data and the buffer has room for it.
    assign rden       = ~empty & (credit_after_pop < 2'd2);
    assign rbin_next  = rbin + PW'(rden);
    assign rgray_next = PW'(bin2gray(32'(rbin_next)));
    assign raddr      = rbin[ADDR_WIDTH-1:0];

    // Pointer, empty flag and in-flight marker; wptr_sync is only compared.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rbin     <= '0;
            rptr     <= '0;
            empty    <= 1'b1;
            inflight <= 1'b0;
        end else begin
            rbin     <= rbin_next;
            rptr     <= rgray_next;
            empty    <= (rgray_next == wptr_sync);
            inflight <= rden;
        end
    end

    // Memory data lands one clock after rden and is captured by the buffer.
    fwft_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (rclk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (mem_rdata),
        .pop        (pop),
        .count      (buf_count),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

`ifdef RPTR_RLEVEL_EN
    logic [ADDR_WIDTH:0] wbin_sync;
    logic [ADDR_WIDTH:0] level_next;

    assign wbin_sync  = PW'(gray2bin(32'(wptr_sync)));
    assign level_next = wbin_sync - rbin_next;

    // Storage occupancy as seen after this cycle's read, modulo pointer range.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rlevel       <= '0;
            almost_empty <= 1'b1;
        end else begin
            rlevel       <= level_next;
            almost_empty <= (32'(level_next) <= ALMOST_EMPTY_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft (ADDR_WIDTH=3, DATA_WIDTH=8): directed scenarios
// plus randomized traffic against a queue-level model of the read side.
module tb_rptr_empty_fwft;

    logic       rclk;
    logic       rst;
    logic       clk_en;
    logic [3:0] wptr_sync;
    logic [3:0] rptr;
    logic [2:0] raddr;
    logic       rden;
    logic [7:0] mem_rdata;
    logic       empty;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
`ifdef RPTR_RLEVEL_EN
    logic [3:0] rlevel;
    logic       almost_empty;
`endif

    rptr_empty_fwft dut (
        .rclk         (rclk),
        .rst          (rst),
        .wptr_sync    (wptr_sync),
        .rptr         (rptr),
        .raddr        (raddr),
        .rden         (rden),
        .mem_rdata    (mem_rdata),
        .empty        (empty),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready)
`ifdef RPTR_RLEVEL_EN
        ,
        .rlevel       (rlevel),
        .almost_empty (almost_empty)
`endif
    );

    initial begin
        rclk = 1'b0;
        forever begin
            #5;
            if (clk_en) rclk = ~rclk;
        end
    end

    // Storage array and its synchronous read port.
    logic [7:0] mem [8];
    always @(posedge rclk) begin
        if (rden === 1'b1) mem_rdata <= mem[raddr];
    end

    int n_checks;
    int n_pass;

    // Model state: words read (rb), words written (wb), visible queue, pending read.
    int         rb;
    int         wb;
    logic [7:0] q[$];
    bit         pend;
    logic [7:0] pend_data;
    bit         m_empty;
    int         m_level;

    // Observation logs for directed scenarios.
    int         cyc;
    int         rden_cnt;
    int         first_rd;
    int         last_rd;
    int         first_pop;
    int         last_pop;
    bit         empty_bad;
    int         raddr_log[$];
    logic [3:0] rptr_log[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [3:0] gray4(input int b);
        int x;
        x = b & 15;
        return 4'(x ^ (x >> 1));
    endfunction

    task automatic clear_logs();
        rden_cnt = 0; first_rd = -1; last_rd = -1;
        first_pop = -1; last_pop = -1; empty_bad = 0;
        raddr_log.delete(); rptr_log.delete(); got.delete();
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[3'(wb)] = d;
        wb++;
        wptr_sync = gray4(wb);
    endtask

    task automatic check_reset_outputs();
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_dout_valid", 32'(dout_valid), 32'(0));
        chk("rst_rptr", 32'(rptr), 32'(0));
        chk("rst_rden", 32'(rden), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
`ifdef RPTR_RLEVEL_EN
        chk("rst_rlevel", 32'(rlevel), 32'(0));
        chk("rst_almost_empty", 32'(almost_empty), 32'(1));
`endif
    endtask

    task automatic model_reset();
        wb = 0; rb = 0; q.delete(); pend = 0; m_empty = 1; m_level = 0;
        wptr_sync = 4'd0;
    endtask

    // Reset applied away from any clock edge; returns just after a falling edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        dout_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge rclk);
        @(negedge rclk);
        rst = 1'b0;
    endtask

    // One clock: drive ready, compare everything against the model, advance it.
    task automatic step(input bit rdy);
        bit exp_rden;
        bit pop;
        int held;
        dout_ready = rdy;
        #1;
        pop      = rdy && (q.size() > 0);
        held     = q.size() + (pend ? 1 : 0);
        exp_rden = !m_empty && ((held - (pop ? 1 : 0)) < 2);
        chk("rden", 32'(rden), 32'(exp_rden));
        if (exp_rden) chk("raddr", 32'(raddr), 32'(rb % 8));
        chk("rptr", 32'(rptr), 32'(gray4(rb)));
        chk("empty", 32'(empty), 32'(m_empty));
        chk("dout_valid", 32'(dout_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
`ifdef RPTR_RLEVEL_EN
        chk("rlevel", 32'(rlevel), 32'(m_level));
        chk("almost_empty", 32'(almost_empty), 32'(m_level <= 2));
`endif
        if (rden === 1'b1) begin
            rden_cnt++;
            raddr_log.push_back(int'(raddr));
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (empty !== 1'b0) empty_bad = 1;
        end
        if (rptr_log.size() == 0 || rptr_log[$] !== rptr) rptr_log.push_back(rptr);
        if (dout_valid === 1'b1 && rdy) begin
            got.push_back(dout);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge rclk);
        if (pop) void'(q.pop_front());
        if (pend) q.push_back(pend_data);
        pend = exp_rden;
        if (exp_rden) begin
            pend_data = mem[3'(rb)];
            rb++;
        end
        m_empty = ((rb % 16) == (wb % 16));
        m_level = (wb - rb) & 15;
        cyc++;
        @(negedge rclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int bias;
        n_checks = 0; n_pass = 0; cyc = 0;
        clk_en = 1'b0; rst = 1'b0; dout_ready = 1'b0;
        model_reset();
        clear_logs();

        // Reset with the clock stopped takes effect immediately.
        #3 rst = 1'b1;
        #1 check_reset_outputs();
        #5 clk_en = 1'b1;
        @(negedge rclk);
        @(negedge rclk);
        rst = 1'b0;

        // Single word: empty/rden/capture latency and hold under backpressure.
        write_word(8'hA5);
        step(0);
        chk("t2_empty_fall", 32'(empty), 32'(0));
        chk("t2_rden", 32'(rden), 32'(1));
        chk("t2_raddr", 32'(raddr), 32'(0));
        step(0);
        chk("t2_empty_back", 32'(empty), 32'(1));
        chk("t2_rptr", 32'(rptr), 32'(4'b0001));
        chk("t2_valid_early", 32'(dout_valid), 32'(0));
        step(0);
        chk("t2_valid", 32'(dout_valid), 32'(1));
        chk("t2_dout", 32'(dout), 32'(8'hA5));
        step(0);
        step(0);
        chk("t2_hold_valid", 32'(dout_valid), 32'(1));
        chk("t2_hold_dout", 32'(dout), 32'(8'hA5));
        step(1);
        chk("t2_popped", 32'(dout_valid), 32'(0));

        // Full rate: eight words streamed with no bubbles.
        do_reset();
        clear_logs();
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        chk("t3_wptr", 32'(wptr_sync), 32'(4'b1100));
        for (int i = 0; i < 14; i++) step(1);
        chk("t3_rden_cnt", 32'(rden_cnt), 32'(8));
        chk("t3_rden_span", 32'(last_rd - first_rd), 32'(7));
        for (int i = 0; i < raddr_log.size(); i++) chk("t3_raddr_seq", 32'(raddr_log[i]), 32'(i));
        chk("t3_got_cnt", 32'(got.size()), 32'(8));
        for (int i = 0; i < got.size(); i++) chk("t3_dout_seq", 32'(got[i]), 32'(8'h10 + i));
        chk("t3_pop_span", 32'(last_pop - first_pop), 32'(7));
        chk("t3_rptr_end", 32'(rptr), 32'(4'b1100));
        chk("t3_empty_end", 32'(empty), 32'(1));

        // Backpressure: only two words leave storage until the consumer pops.
        do_reset();
        clear_logs();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'($urandom));
            write_word(exp_q[i]);
        end
        for (int i = 0; i < 10; i++) step(0);
        chk("t4_rden_cnt", 32'(rden_cnt), 32'(2));
        chk("t4_rden_idle", 32'(rden), 32'(0));
        chk("t4_valid_held", 32'(dout_valid), 32'(1));
        for (int i = 0; i < 14; i++) step(1);
        chk("t4_got_cnt", 32'(got.size()), 32'(8));
        for (int i = 0; i < got.size() && i < 8; i++) chk("t4_order", 32'(got[i]), 32'(exp_q[i]));

        // Pointer wrap from rbin=14 through zero.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            write_word(8'($urandom));
            step(1);
        end
        for (int i = 0; i < 10; i++) step(1);
        chk("t5_rptr_primed", 32'(rptr), 32'(4'b1001));
        clear_logs();
        for (int i = 0; i < 4; i++) write_word(8'($urandom));
        chk("t5_wptr", 32'(wptr_sync), 32'(4'b0011));
        for (int i = 0; i < 8; i++) step(1);
        chk("t5_rden_cnt", 32'(rden_cnt), 32'(4));
        if (raddr_log.size() == 4) begin
            chk("t5_raddr0", 32'(raddr_log[0]), 32'(6));
            chk("t5_raddr1", 32'(raddr_log[1]), 32'(7));
            chk("t5_raddr2", 32'(raddr_log[2]), 32'(0));
            chk("t5_raddr3", 32'(raddr_log[3]), 32'(1));
        end
        chk("t5_rptr_steps", 32'(rptr_log.size()), 32'(5));
        if (rptr_log.size() == 5) begin
            chk("t5_rptr_s1", 32'(rptr_log[1]), 32'(4'b1000));
            chk("t5_rptr_s2", 32'(rptr_log[2]), 32'(4'b0000));
            chk("t5_rptr_s3", 32'(rptr_log[3]), 32'(4'b0001));
        end
        chk("t5_empty_during", 32'(empty_bad), 32'(0));
        chk("t5_rptr_end", 32'(rptr), 32'(4'b0011));
        chk("t5_empty_end", 32'(empty), 32'(1));

`ifdef RPTR_RLEVEL_EN
        // Read-side level and almost_empty tracking.
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'(8'h50 + i));
        chk("t6_wptr", 32'(wptr_sync), 32'(4'b0111));
        step(0);
        chk("t6_lvl5", 32'(rlevel), 32'(5));
        step(0);
        chk("t6_lvl4", 32'(rlevel), 32'(4));
        step(0);
        chk("t6_lvl3", 32'(rlevel), 32'(3));
        step(0);
        step(0);
        chk("t6_lvl3_hold", 32'(rlevel), 32'(3));
        chk("t6_ae0", 32'(almost_empty), 32'(0));
        step(1);
        chk("t6_lvl2", 32'(rlevel), 32'(2));
        chk("t6_ae1", 32'(almost_empty), 32'(1));
        step(1);
        chk("t6_lvl1", 32'(rlevel), 32'(1));
        step(1);
        chk("t6_lvl0", 32'(rlevel), 32'(0));
        chk("t6_ae_end", 32'(almost_empty), 32'(1));
        for (int i = 0; i < 6; i++) step(1);
`endif

        // Randomized traffic with shifting backpressure and one mid-run reset.
        do_reset();
        bias = 90;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                case ($urandom_range(0, 3))
                    0: bias = 100;
                    1: bias = 70;
                    2: bias = 30;
                    default: bias = 5;
                endcase
            end
            if (i == 1500) do_reset();
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                if (wb - rb < 8) write_word(8'($urandom));
            end
            step($urandom_range(0, 99) < bias);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
